// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the matrix-multiply accumulator stage: lane count,
// datapath widths, drain FSM state encoding and the saturation limits used by
// the accumulator adders and the int8 requantizer.
// ----------------------------------------------------------------------------
package tpu_pkg;

    localparam int LANES  = 16;
    localparam int PSUM_W = 20;
    localparam int ACC_W  = 32;
    localparam int ACT_W  = 8;

    // Accumulator saturation limits.
    localparam logic signed [ACC_W-1:0] ACC_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] ACC_MIN = 32'sh8000_0000;

    // int8 activation limits, held at accumulator width for direct compares.
    localparam logic signed [ACC_W-1:0] ACT_MAX = 32'sd127;
    localparam logic signed [ACC_W-1:0] ACT_MIN = -32'sd128;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } drain_state_e;

endpackage

// File: rtl/mmu_accumulator_if.sv
// ----------------------------------------------------------------------------
// mmu_accumulator_if
// Bundles the partial-sum write port, the drain command and the valid/ready
// activation output of mmu_accumulator.
//   master : producer/consumer side (drives psum_*, drain_start, shift,
//            out_ready; observes out_*, busy, done)
//   slave  : accumulator side
// ----------------------------------------------------------------------------
interface mmu_accumulator_if #(
    parameter int ADDR_W = 4
);
    import tpu_pkg::*;

    logic                      psum_valid;
    logic [ADDR_W-1:0]         psum_addr;
    logic                      psum_acc;
    logic [LANES*PSUM_W-1:0]   psum_in;
    logic                      drain_start;
    logic [4:0]                shift;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*ACT_W-1:0]    out_data;
    logic [ADDR_W-1:0]         out_addr;
    logic                      busy;
    logic                      done;

    modport master (
        output psum_valid, psum_addr, psum_acc, psum_in,
        output drain_start, shift, out_ready,
        input  out_valid, out_data, out_addr, busy, done
    );

    modport slave (
        input  psum_valid, psum_addr, psum_acc, psum_in,
        input  drain_start, shift, out_ready,
        output out_valid, out_data, out_addr, busy, done
    );

endinterface

// File: rtl/requant_lane.sv
// ----------------------------------------------------------------------------
// requant_lane
// Combinational requantizer for one lane: 32-bit accumulator -> int8.
// Rounds half-up by adding 2^(shift-1) (saturating), arithmetic right shift,
// optional ReLU, then clamps to [-128, 127].
// Optional feature macro: TPU_ACC_RELU_EN (negative results forced to 0).
// Ports:
//   acc_in  : signed accumulator value
//   shift   : right-shift amount 0..31
//   act_out : signed int8 activation
// ----------------------------------------------------------------------------
module requant_lane
    import tpu_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic        [4:0]       shift,
    output logic signed [ACT_W-1:0] act_out
);

    localparam logic signed [ACC_W:0] ONE_X = {{ACC_W{1'b0}}, 1'b1};

    // Add the rounding bias in one extra bit; only positive overflow is
    // possible because the bias is never negative.
    function automatic logic signed [ACC_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] x,
        input logic        [4:0]       s
    );
        logic signed [ACC_W:0]   sum;
        logic signed [ACC_W-1:0] res;
        sum = {x[ACC_W-1], x} + (ONE_X << (s - 5'd1));
        if (s == 5'd0) begin
            res = x;
        end else if (sum[ACC_W] != sum[ACC_W-1]) begin
            res = ACC_MAX;
        end else begin
            res = sum[ACC_W-1:0];
        end
        return res;
    endfunction

    function automatic logic signed [ACT_W-1:0] sat_act(
        input logic signed [ACC_W-1:0] x
    );
        logic signed [ACT_W-1:0] res;
        if (x > ACT_MAX) begin
            res = ACT_MAX[ACT_W-1:0];
        end else if (x < ACT_MIN) begin
            res = ACT_MIN[ACT_W-1:0];
        end else begin
            res = x[ACT_W-1:0];
        end
        return res;
    endfunction

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] relu_v;

    always_comb begin
        rounded = round_sat(acc_in, shift);
        shifted = rounded >>> shift;
`ifdef TPU_ACC_RELU_EN
        relu_v  = shifted[ACC_W-1] ? '0 : shifted;
`else
        relu_v  = shifted;
`endif
        act_out = sat_act(relu_v);
    end

endmodule

// File: rtl/mmu_accumulator.sv
// ----------------------------------------------------------------------------
// mmu_accumulator
// Accumulator bank behind the 16x16 matrix multiply unit. Each 320-bit psum
// row (16 signed 20-bit lanes) overwrites or saturating-accumulates into a
// DEPTH x 16 bank of 32-bit accumulators. drain_start walks rows 0..DEPTH-1
// through 16 requant_lane instances and presents each as a 128-bit int8 word
// on a valid/ready port.
// Optional feature macro: TPU_ACC_RELU_EN (ReLU inside requant_lane).
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : mmu_accumulator_if.slave (psum write, drain command, output)
// ----------------------------------------------------------------------------
module mmu_accumulator
    import tpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    mmu_accumulator_if.slave bus
);

    function automatic logic signed [ACC_W-1:0] sext_psum(
        input logic [PSUM_W-1:0] p
    );
        return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0]   sum;
        logic signed [ACC_W-1:0] res;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            res = sum[ACC_W-1:0];
        end
        return res;
    endfunction

    logic signed [ACC_W-1:0]  acc_mem [DEPTH][LANES];

    drain_state_e             state_q;
    drain_state_e             state_d;
    logic [ADDR_W-1:0]        ptr_q;
    logic [4:0]               shift_q;
    logic [LANES*ACT_W-1:0]   requant_row;
    logic [LANES*ACT_W-1:0]   out_data_q;
    logic [ADDR_W-1:0]        out_addr_q;
    logic                     done_q;
    logic                     done_d;
    logic                     start_en;
    logic                     fetch_en;
    logic                     ptr_inc;
    logic                     last_row;
    logic                     wr_en;

    // Writes are only accepted while idle; out-of-range rows are dropped.
    assign wr_en    = bus.psum_valid && (state_q == IDLE) && (int'(bus.psum_addr) < DEPTH);
    assign last_row = (ptr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    acc_mem[r][l] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.psum_acc) begin
                    acc_mem[bus.psum_addr][l] <= sat_add(acc_mem[bus.psum_addr][l],
                                                         sext_psum(bus.psum_in[l*PSUM_W +: PSUM_W]));
                end else begin
                    acc_mem[bus.psum_addr][l] <= sext_psum(bus.psum_in[l*PSUM_W +: PSUM_W]);
                end
            end
        end
    end

    // Requantize the row under the drain pointer.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        requant_lane u_requant (
            .acc_in  (acc_mem[ptr_q][g]),
            .shift   (shift_q),
            .act_out (requant_row[g*ACT_W +: ACT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_en = 1'b0;
        fetch_en = 1'b0;
        ptr_inc  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.drain_start) begin
                    start_en = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                fetch_en = 1'b1;
                state_d  = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (last_row) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ptr_inc = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FETCH -> PRESENT boundary: output word registered here and held
    // unchanged until the handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            shift_q    <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= done_d;
            if (start_en) begin
                shift_q <= bus.shift;
                ptr_q   <= '0;
            end else if (ptr_inc) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if (fetch_en) begin
                out_data_q <= requant_row;
                out_addr_q <= ptr_q;
            end
        end
    end

    assign bus.out_valid = (state_q == PRESENT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_mmu_accumulator.sv
// ----------------------------------------------------------------------------
// tb_mmu_accumulator
// Self-checking bench for mmu_accumulator: table of write/drain vectors plus
// hand-written sequences for saturation, same-cycle write+drain, backpressure
// and reset in the middle of a drain. Expected rows come from a longint
// reference model and are queued when each drain starts.
// ----------------------------------------------------------------------------
module tb_mmu_accumulator;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int NL     = 16;

`ifdef TPU_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk;
    logic rst_n;

    mmu_accumulator_if #(.ADDR_W(ADDR_W)) bus ();

    mmu_accumulator #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        int row;
        int nops;
        int v0;
        int v1;
        bit a1;
        int v2;
        bit a2;
        int sh;
        int exp_lane;
    } vec_t;

    exp_t         sb_q[$];
    longint       macc [DEPTH][NL];
    logic [127:0] cap [DEPTH];
    vec_t         vecs [11];
    int           n_checks;
    int           n_fail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [319:0] lanes_uniform(input int v);
        logic [319:0] d;
        logic [19:0]  p;
        p = v[19:0];
        for (int l = 0; l < NL; l++) d[20*l +: 20] = p;
        return d;
    endfunction

    function automatic logic [127:0] rep_lane(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {16{b}};
    endfunction

    function automatic int m_requant(input longint x, input int s);
        longint y;
        y = x;
        if (s > 0) begin
            y = y + (longint'(1) << (s - 1));
            if (y > 64'sd2147483647) y = 64'sd2147483647;
        end
        y = y >>> s;
        if (RELU && y < 0) y = 0;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return int'(y);
    endfunction

    function automatic logic [127:0] model_row(input int r, input int s);
        logic [127:0] d;
        int q;
        for (int l = 0; l < NL; l++) begin
            q = m_requant(macc[r][l], s);
            d[8*l +: 8] = q[7:0];
        end
        return d;
    endfunction

    task automatic model_apply(input int addr, input bit acc, input logic [319:0] data);
        longint pv;
        longint v;
        for (int l = 0; l < NL; l++) begin
            pv = longint'($signed(data[20*l +: 20]));
            v  = acc ? macc[addr][l] + pv : pv;
            if (v > 64'sd2147483647) v = 64'sd2147483647;
            if (v < -64'sd2147483648) v = -64'sd2147483648;
            macc[addr][l] = v;
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++)
            for (int l = 0; l < NL; l++) macc[r][l] = 0;
    endtask

    task automatic psum_write(input int addr, input bit acc, input logic [319:0] data);
        bus.psum_valid = 1'b1;
        bus.psum_addr  = addr[3:0];
        bus.psum_acc   = acc;
        bus.psum_in    = data;
        tick();
        bus.psum_valid = 1'b0;
        model_apply(addr, acc, data);
    endtask

    // Full drain with optional backpressure/poke on one row, optional reset
    // when a given row is presented, and optional write in the start cycle.
    task automatic run_drain(input int sh, input int stall_row, input int stall_cycles,
                             input bit poke, input int abort_row,
                             input bit sim_wr, input int sim_addr, input int sim_val);
        bit   fin;
        int   stall_cnt;
        int   first_v;
        int   exp_done;
        exp_t e;
        logic [319:0] wd;
        fin       = 1'b0;
        stall_cnt = 0;
        first_v   = -1;
        exp_done  = 2*DEPTH + 1 + stall_cycles;
        if (sim_wr) begin
            wd = lanes_uniform(sim_val);
            bus.psum_valid = 1'b1;
            bus.psum_addr  = sim_addr[3:0];
            bus.psum_acc   = 1'b0;
            bus.psum_in    = wd;
            model_apply(sim_addr, 1'b0, wd);
        end
        for (int r = 0; r < DEPTH; r++) begin
            e.addr = r[3:0];
            e.data = model_row(r, sh);
            sb_q.push_back(e);
        end
        bus.shift       = sh[4:0];
        bus.drain_start = 1'b1;
        bus.out_ready   = 1'b1;
        tick();
        bus.drain_start = 1'b0;
        bus.psum_valid  = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("valid_after_start", bus.out_valid, 0);
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            if (bus.done) begin
                fin = 1'b1;
                check("done_cycle", cyc, exp_done);
                check("busy_at_done", bus.busy, 0);
                check("rows_left_at_done", sb_q.size(), 0);
                tick();
                check("done_one_cycle", bus.done, 0);
            end else begin
                bus.psum_valid  = 1'b0;
                bus.drain_start = 1'b0;
                if (!bus.out_valid) begin
                    tick();
                end else begin
                    if (first_v < 0) begin
                        first_v = cyc;
                        check("first_valid_cycle", cyc, 2);
                    end
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_row actual_addr=%0d required=none", bus.out_addr);
                        fin = 1'b1;
                    end else if (abort_row >= 0 && int'(bus.out_addr) == abort_row) begin
                        rst_n         = 1'b0;
                        bus.out_ready = 1'b0;
                        tick();
                        check("abort_busy", bus.busy, 0);
                        check("abort_valid", bus.out_valid, 0);
                        check("abort_done", bus.done, 0);
                        check("abort_data", bus.out_data, 0);
                        check("abort_addr", bus.out_addr, 0);
                        rst_n = 1'b1;
                        sb_q.delete();
                        model_clear();
                        fin = 1'b1;
                    end else if (int'(bus.out_addr) == stall_row && stall_cnt < stall_cycles) begin
                        bus.out_ready = 1'b0;
                        check("stall_addr", bus.out_addr, sb_q[0].addr);
                        check("stall_data", bus.out_data, sb_q[0].data);
                        if (poke) begin
                            bus.psum_valid  = 1'b1;
                            bus.psum_addr   = stall_row[3:0];
                            bus.psum_acc    = 1'b0;
                            bus.psum_in     = lanes_uniform(55);
                            bus.drain_start = 1'b1;
                        end
                        stall_cnt++;
                        tick();
                    end else begin
                        bus.out_ready = 1'b1;
                        e = sb_q.pop_front();
                        check($sformatf("row%0d_addr", e.addr), bus.out_addr, e.addr);
                        check($sformatf("row%0d_data", e.addr), bus.out_data, e.data);
                        cap[bus.out_addr] = bus.out_data;
                        tick();
                    end
                end
            end
        end
        bus.out_ready = 1'b1;
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout actual=no_done required=done");
            sb_q.delete();
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.psum_valid  = 1'b0;
        bus.psum_addr   = '0;
        bus.psum_acc    = 1'b0;
        bus.psum_in     = '0;
        bus.drain_start = 1'b0;
        bus.shift       = '0;
        bus.out_ready   = 1'b0;
        model_clear();

        vecs[0]  = '{3,  1, 100,     0,    1'b0, 0,   1'b0, 0,  100};
        vecs[1]  = '{0,  3, 300,     200,  1'b1, 200, 1'b1, 2,  127};
        vecs[2]  = '{1,  1, -20,     0,    1'b0, 0,   1'b0, 1,  RELU ? 0 : -10};
        vecs[3]  = '{5,  1, -1000,   0,    1'b0, 0,   1'b0, 3,  RELU ? 0 : -125};
        vecs[4]  = '{4,  1, 6,       0,    1'b0, 0,   1'b0, 2,  2};
        vecs[5]  = '{6,  1, 1000,    0,    1'b0, 0,   1'b0, 0,  127};
        vecs[6]  = '{6,  1, -1000,   0,    1'b0, 0,   1'b0, 0,  RELU ? 0 : -128};
        vecs[7]  = '{2,  2, -300,    -200, 1'b1, 0,   1'b0, 2,  RELU ? 0 : -125};
        vecs[8]  = '{10, 1, 7,       0,    1'b0, 0,   1'b0, 1,  4};
        vecs[9]  = '{11, 1, -524288, 0,    1'b0, 0,   1'b0, 12, RELU ? 0 : -128};
        vecs[10] = '{7,  2, -100,    50,   1'b0, 0,   1'b0, 0,  50};

        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_addr", bus.out_addr, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            psum_write(vecs[i].row, 1'b0, lanes_uniform(vecs[i].v0));
            if (vecs[i].nops > 1) psum_write(vecs[i].row, vecs[i].a1, lanes_uniform(vecs[i].v1));
            if (vecs[i].nops > 2) psum_write(vecs[i].row, vecs[i].a2, lanes_uniform(vecs[i].v2));
            run_drain(vecs[i].sh, -1, 0, 1'b0, -1, 1'b0, 0, 0);
            check($sformatf("vec%0d_row%0d", i, vecs[i].row), cap[vecs[i].row], rep_lane(vecs[i].exp_lane));
        end

        // Per-lane distinct values on row 9.
        begin
            logic [319:0] d;
            int           v;
            for (int l = 0; l < NL; l++) begin
                v = (l - 8) * 30000;
                d[20*l +: 20] = v[19:0];
            end
            psum_write(9, 1'b0, d);
            run_drain(11, -1, 0, 1'b0, -1, 1'b0, 0, 0);
        end

        // Accumulator saturation at +2^31-1, no wrap.
        psum_write(8, 1'b0, lanes_uniform(524287));
        for (int k = 0; k < 4097; k++) psum_write(8, 1'b1, lanes_uniform(524287));
        run_drain(24, -1, 0, 1'b0, -1, 1'b0, 0, 0);
        check("sat_shift24", cap[8], rep_lane(127));
        run_drain(31, -1, 0, 1'b0, -1, 1'b0, 0, 0);
        check("sat_shift31", cap[8], rep_lane(0));

        // Write and drain_start in the same idle cycle.
        run_drain(0, -1, 0, 1'b0, -1, 1'b1, 0, 40);
        check("same_cycle_row0", cap[0], rep_lane(40));

        // Backpressure on row 2 with an ignored write and drain_start.
        run_drain(0, 2, 5, 1'b1, -1, 1'b0, 0, 0);
        run_drain(2, -1, 0, 1'b0, -1, 1'b0, 0, 0);
        check("row2_unchanged", cap[2], rep_lane(RELU ? 0 : -125));

        // Reset while row 7 is presented, then confirm the bank is cleared.
        run_drain(0, -1, 0, 1'b0, 7, 1'b0, 0, 0);
        tick();
        run_drain(0, -1, 0, 1'b0, -1, 1'b0, 0, 0);
        check("cleared_row3", cap[3], rep_lane(0));
        check("cleared_row8", cap[8], rep_lane(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
